// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port block RAM.
// One transaction is in flight at a time: grant (IDLE), drive the RAM
// (ISSUE), take the registered read word (CAPTURE), then a one-cycle ack.
module bram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t state;
    state_t state_next;

    logic              last;
    logic              sel;
    logic              we_l;
    logic              grant;
    logic              winner;
    logic              elig0;
    logic              elig1;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_din;
    logic              win_we;

    // Next-state, arbitration and RAM strobe; a port is masked during its own ack cycle
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        winner     = 1'b0;
        elig0      = req0 & ~ack0;
        elig1      = req1 & ~ack1;
        case (state)
            IDLE: begin
                if (elig0 | elig1) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                    if (elig0 & elig1) begin
                        winner = ~last;
                    end else begin
                        winner = elig1;
                    end
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        win_addr = winner ? addr1 : addr0;
        win_din  = winner ? din1  : din0;
        win_we   = winner ? we1   : we0;
        ram_we   = (state == ISSUE) & we_l;
        busy     = (state != IDLE);
    end

    // State register; reset drops out of ISSUE at once so a pending write never lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's request at grant, return read data and ack at the end of CAPTURE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            we_l     <= 1'b0;
            sel      <= 1'b0;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (grant) begin
                ram_addr <= win_addr;
                ram_din  <= win_din;
                we_l     <= win_we;
                sel      <= winner;
            end
            if (state == CAPTURE) begin
                last <= sel;
                if (sel) begin
                    ack1 <= 1'b1;
                    if (!we_l) begin
                        rdata1 <= ram_out;
                    end
                end else begin
                    ack0 <= 1'b1;
                    if (!we_l) begin
                        rdata0 <= ram_out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: a behavioural block RAM, two
// requesters (directed or random) and a transaction-level reference that
// predicts grant edges, ack cycles and read data from the arbitration rules.
module tb_bram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] din0, din1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_out;
    logic              busy;

    // Requester-side drive values
    logic              r_req  [2];
    logic              r_we   [2];
    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_din  [2];
    bit                auto_p [2];
    int                prob   [2];
    bit                done   [2];
    int                ack_cyc[2];

    // Reference model state (edge counts since the last reset release)
    int                edge_n;
    int                free_edge;
    int                last_p;
    int                ack_edge [2];
    bit                granted  [2];
    int                g_edge;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_din;
    logic              pend_we   [2];
    logic [ADDR_W-1:0] pend_addr [2];
    logic [DATA_W-1:0] pend_din  [2];
    logic [DATA_W-1:0] exp_rdata [2];
    logic [DATA_W-1:0] ref_wr [int];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    assign req0  = r_req[0];
    assign req1  = r_req[1];
    assign we0   = r_we[0];
    assign we1   = r_we[1];
    assign addr0 = r_addr[0];
    assign addr1 = r_addr[1];
    assign din0  = r_din[0];
    assign din1  = r_din[1];

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_out(ram_out), .busy(busy)
    );

    // Single-port block RAM with a one-cycle registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_out <= mem[ram_addr];
    end

    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
        return 32'hC0DE0000 ^ {a, 17'h0} ^ {17'h0, a};
    endfunction

    function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return preload(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    task automatic resetModel();
        edge_n    = 0;
        free_edge = 0;
        last_p    = 1;
        g_edge    = -100;
        for (int p = 0; p < 2; p++) begin
            ack_edge[p]  = -100;
            granted[p]   = 1'b0;
            exp_rdata[p] = '0;
        end
    endtask

    task automatic newTxn(input int p);
        r_req[p]  = 1'b1;
        r_we[p]   = ($urandom_range(0, 2) == 0);
        r_addr[p] = ($urandom_range(0, 15) == 0) ? ADDR_W'(15'h7FFF) : ADDR_W'($urandom_range(0, 31));
        r_din[p]  = $urandom;
    endtask

    // One clock: check this cycle's outputs, update requesters, predict the next edge
    task automatic stepCycle();
        bit exp_ack [2];
        bit elig    [2];
        int w;
        for (int p = 0; p < 2; p++) begin
            exp_ack[p] = (ack_edge[p] == edge_n);
            checkOutput($sformatf("ack%0d", p), 64'(p == 0 ? ack0 : ack1), 64'(exp_ack[p]));
            if (exp_ack[p]) begin
                if (pend_we[p]) ref_wr[int'(pend_addr[p])] = pend_din[p];
                else exp_rdata[p] = refRead(pend_addr[p]);
            end
        end
        if (exp_ack[0] || exp_ack[1]) begin
            checkOutput("rdata0", 64'(rdata0), 64'(exp_rdata[0]));
            checkOutput("rdata1", 64'(rdata1), 64'(exp_rdata[1]));
        end
        checkOutput("busy", 64'(busy), 64'((g_edge == edge_n) || (g_edge + 1 == edge_n)));
        checkOutput("ram_we", 64'(ram_we), 64'((g_edge == edge_n) && g_we));
        if (g_edge == edge_n) begin
            checkOutput("ram_addr", 64'(ram_addr), 64'(g_addr));
            checkOutput("ram_din", 64'(ram_din), 64'(g_din));
        end
        for (int p = 0; p < 2; p++) begin
            if (exp_ack[p]) begin
                granted[p] = 1'b0;
                done[p]    = 1'b1;
                ack_cyc[p] = edge_n;
                if (auto_p[p] && $urandom_range(0, 99) < prob[p]) newTxn(p);
                else r_req[p] = 1'b0;
            end else if (auto_p[p] && !r_req[p]) begin
                if ($urandom_range(0, 99) < prob[p]) newTxn(p);
            end else if (auto_p[p] && r_req[p] && !granted[p] && $urandom_range(0, 3) == 0) begin
                newTxn(p);
            end
        end
        if (edge_n + 1 >= free_edge) begin
            for (int p = 0; p < 2; p++) elig[p] = r_req[p] && !exp_ack[p] && !granted[p];
            w = -1;
            if (elig[0] && elig[1]) w = (last_p == 0) ? 1 : 0;
            else if (elig[0]) w = 0;
            else if (elig[1]) w = 1;
            if (w >= 0) begin
                g_edge       = edge_n + 1;
                g_we         = r_we[w];
                g_addr       = r_addr[w];
                g_din        = r_din[w];
                pend_we[w]   = r_we[w];
                pend_addr[w] = r_addr[w];
                pend_din[w]  = r_din[w];
                ack_edge[w]  = edge_n + 3;
                free_edge    = edge_n + 4;
                last_p       = w;
                granted[w]   = 1'b1;
            end
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic waitDone(input int p);
        for (int i = 0; i < 30 && !done[p]; i++) stepCycle();
        if (!done[p]) checkOutput($sformatf("timeout_port%0d", p), 64'(0), 64'(1));
    endtask

    task automatic applyStimulus(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        r_req[p]  = 1'b1;
        r_we[p]   = we;
        r_addr[p] = a;
        r_din[p]  = d;
        done[p]   = 1'b0;
        waitDone(p);
    endtask

    task automatic applyReset();
        for (int p = 0; p < 2; p++) r_req[p] = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_ram_we", 64'(ram_we), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack", 64'({ack1, ack0}), 64'(0));
        checkOutput("rst_rdata0", 64'(rdata0), 64'(0));
        checkOutput("rst_rdata1", 64'(rdata1), 64'(0));
        checkOutput("rst_ram_addr", 64'(ram_addr), 64'(0));
        checkOutput("rst_ram_din", 64'(ram_din), 64'(0));
        rst = 1'b0;
        resetModel();
    endtask

    // Main sequence: directed cases, random phases, reset during a write
    initial begin
        logic [DATA_W-1:0] old_val;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = preload(ADDR_W'(i));
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_din[p] = '0;
            auto_p[p] = 1'b0; prob[p] = 0; done[p] = 1'b0; ack_cyc[p] = 0;
            pend_we[p] = 1'b0; pend_addr[p] = '0; pend_din[p] = '0;
        end
        g_we = 1'b0; g_addr = '0; g_din = '0;
        rst = 1'b1;
        resetModel();
        @(negedge clk);
        applyReset();

        applyStimulus(0, 1'b1, 15'h0010, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 15'h0010, 32'h0);
        checkOutput("p0_write_read", 64'(rdata0), 64'(32'hDEADBEEF));
        applyStimulus(1, 1'b1, 15'h07FF, 32'h12345678);
        checkOutput("p1_write_keeps_rdata1", 64'(rdata1), 64'(0));
        applyStimulus(0, 1'b0, 15'h07FF, 32'h0);
        checkOutput("p0_reads_p1_write", 64'(rdata0), 64'(32'h12345678));

        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 15'h0005; done[0] = 1'b0;
        stepCycle();
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 15'h0006; done[1] = 1'b0;
        stepCycle();
        r_addr[1] = 15'h0009;
        waitDone(0);
        waitDone(1);
        checkOutput("late_addr_change", 64'(rdata1), 64'(refRead(15'h0009)));

        for (int ph = 0; ph < 3; ph++) begin
            prob[0] = (ph == 0) ? 100 : (ph == 1) ? 100 : 50;
            prob[1] = (ph == 0) ? 0   : (ph == 1) ? 100 : 50;
            auto_p[0] = 1'b1;
            auto_p[1] = 1'b1;
            for (int i = 0; i < 600; i++) stepCycle();
            auto_p[0] = 1'b0;
            auto_p[1] = 1'b0;
            for (int i = 0; i < 14; i++) stepCycle();
        end

        old_val = refRead(15'h0020);
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 15'h0020; r_din[1] = 32'hAAAA5555;
        stepCycle();
        checkOutput("issue_ram_we", 64'(ram_we), 64'(1));
        checkOutput("issue_ram_addr", 64'(ram_addr), 64'(15'h0020));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midissue_ram_we", 64'(ram_we), 64'(0));
        checkOutput("midissue_busy", 64'(busy), 64'(0));
        r_req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midissue_no_ack1", 64'(ack1), 64'(0));
        rst = 1'b0;
        resetModel();
        for (int i = 0; i < 4; i++) stepCycle();

        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 15'h0020; done[0] = 1'b0;
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 15'h0021; done[1] = 1'b0;
        waitDone(0);
        waitDone(1);
        checkOutput("tie_after_reset_order", 64'(ack_cyc[1] - ack_cyc[0]), 64'(3));
        checkOutput("cut_write_not_done", 64'(rdata0), 64'(old_val));
        for (int i = 0; i < 4; i++) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
